// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared by instruction fetch and the load/store
// buffer. One multi-byte request is sequenced at a time, with little-endian
// assembly of read data and a one-cycle done pulse to the owner.
module mem_arbiter #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_SEL       = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear_up,
  input  logic                  io_buffer_full,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_in,
  input  logic [7:0]            ram_out,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_we,
  input  logic [1:0]            lsb_size,
  input  logic [31:0]           lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  output logic                  busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  own_lsb_q, own_lsb_d;
  logic                  we_q, we_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [7:0]            hold_byte_q, hold_byte_d;

  logic [2:0] off;
  logic       io_stall;
  logic [7:0] wbyte;
  logic [7:0] cap_byte;
  logic [1:0] bidx;
  logic       fetch_win;
  logic       done_ok;

  // RAM port drive and done pulses, derived from the registered sequencer state.
  always_comb begin
    // Reads keep the last byte address after all addresses are issued.
    off      = (cyc_q >= n_q) ? (n_q - 3'd1) : cyc_q;
    ram_addr = addr_q + ADDR_WIDTH'(off);
    io_stall = (state_q == WRITE) && (addr_q[17:16] == IO_SEL) && io_buffer_full;
    case (cyc_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
    ram_rw = 1'b1;
    ram_in = 8'h00;
    if (state_q == WRITE) begin
      ram_in = wbyte;
      if (rdy_in && !io_stall) ram_rw = 1'b0;
    end
    // A flush in the done cycle of a read cancels the pulse; stores always commit.
    done_ok   = (state_q == DONE) && rdy_in && !(rob_clear_up && !we_q);
    if_done   = done_ok && !own_lsb_q;
    lsb_done  = done_ok && own_lsb_q;
    if_data   = if_data_q;
    lsb_rdata = lsb_rdata_q;
    busy      = (state_q != IDLE);
  end

  // Arbitration, byte sequencing, capture and flush handling.
  always_comb begin
    state_d     = state_q;
    own_lsb_d   = own_lsb_q;
    we_d        = we_q;
    n_d         = n_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    starve_d    = starve_q;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    fetch_win   = if_req && (!lsb_req || (starve_q == SW'(STARVE_LIMIT)));
    // The byte arriving in the first frozen cycle belongs to the address driven
    // before the freeze; park it so capture picks it up on resume.
    cap_byte    = hold_vld_q ? hold_byte_q : ram_out;
    bidx        = cyc_q[1:0] - 2'd1;

    if (!rdy_in) begin
      if (state_q == READ && !hold_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_byte_d = ram_out;
      end
    end else begin
      hold_vld_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!rob_clear_up) begin
            if (fetch_win) begin
              own_lsb_d = 1'b0;
              we_d      = 1'b0;
              n_d       = 3'd4;
              addr_d    = ADDR_WIDTH'(if_addr);
              starve_d  = '0;
              cyc_d     = 3'd0;
              buf_d     = 32'h0;
              state_d   = READ;
            end else if (lsb_req) begin
              own_lsb_d = 1'b1;
              we_d      = lsb_we;
              case (lsb_size)
                2'd0:    n_d = 3'd1;
                2'd1:    n_d = 3'd2;
                default: n_d = 3'd4;
              endcase
              addr_d  = ADDR_WIDTH'(lsb_addr);
              wdata_d = lsb_wdata;
              cyc_d   = 3'd0;
              buf_d   = 32'h0;
              state_d = lsb_we ? WRITE : READ;
              if (if_req) starve_d = starve_q + SW'(1);
            end
          end
        end
        READ: begin
          if (rob_clear_up) begin
            state_d = IDLE;
          end else begin
            if (cyc_q != 3'd0) begin
              case (bidx)
                2'd0:    buf_d[7:0]   = cap_byte;
                2'd1:    buf_d[15:8]  = cap_byte;
                2'd2:    buf_d[23:16] = cap_byte;
                default: buf_d[31:24] = cap_byte;
              endcase
            end
            if (cyc_q == n_q) begin
              state_d = DONE;
              if (own_lsb_q) lsb_rdata_d = buf_d;
              else           if_data_d   = buf_d;
            end else begin
              cyc_d = cyc_q + 3'd1;
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (cyc_q == n_q - 3'd1) state_d = DONE;
            else                     cyc_d   = cyc_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      own_lsb_q   <= 1'b0;
      we_q        <= 1'b0;
      n_q         <= 3'd1;
      cyc_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_data_q   <= 32'h0;
      lsb_rdata_q <= 32'h0;
      starve_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      own_lsb_q   <= own_lsb_d;
      we_q        <= we_d;
      n_q         <= n_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      starve_q    <= starve_d;
      hold_vld_q  <= hold_vld_d;
      hold_byte_q <= hold_byte_d;
    end
  end

endmodule
